// File: rtl/audio_sched_pkg.sv
// ============================================================================
// Module  : audio_sched_pkg
// Brief   : Shared types and constants for the audio BRAM scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_sched_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module  : word_serializer
// Brief   : Holds one BRAM word and emits its bytes MSB first as trigger strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer
  import audio_sched_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  fire_in,
  input  logic                  step_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_trigger_out,
  output logic                  last_out
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [WORD_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_tx_byte;
  logic                  r_tx_trigger;
  logic [7:0]            w_lane;

  assign w_lane = r_word[{r_idx, 3'b000} +: 8];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_word       <= '0;
      r_idx        <= '0;
      r_tx_byte    <= '0;
      r_tx_trigger <= 1'b0;
    end else begin
      r_tx_trigger <= fire_in;
      if (fire_in) begin
        r_tx_byte <= w_lane;
      end
      if (load_in) begin
        r_word <= word_in;
        r_idx  <= C_LAST_IDX;
      end else if (step_in) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign tx_byte_out    = r_tx_byte;
  assign tx_trigger_out = r_tx_trigger;
  assign last_out       = (r_idx == '0);

endmodule

`default_nettype wire

// File: rtl/audio_bram_scheduler.sv
// ============================================================================
// Module  : audio_bram_scheduler
// Brief   : Arbitrates the shared audio BRAM port between record writes and
//           byte-serialised playback reads. Define AUDIO_SCHED_LOOP_EN for
//           continuous looped playback.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_bram_scheduler
  import audio_sched_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 25_250,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  play_in,
  input  logic                  clear_in,
  input  logic                  wr_valid_in,
  input  logic [WORD_WIDTH-1:0] wr_data_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [WORD_WIDTH-1:0] bram_din_out,
  output logic                  bram_we_out,
  input  logic [WORD_WIDTH-1:0] bram_dout_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_trigger_out,
  input  logic                  tx_busy_in,
  output logic [ADDR_WIDTH:0]   wr_count_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  output logic                  overflow_out,
  output logic                  done_out
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LAT_W-1:0]    C_LAT   = LAT_W'(READ_LATENCY);

  sched_state_t r_state, w_next;

  logic [ADDR_WIDTH:0]   r_wr_count;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LAT_W-1:0]      r_lat;
  logic                  r_overflow;
  logic                  r_play_q;

  logic                  w_wr_ok;
  logic                  w_play_rise;
  logic [ADDR_WIDTH:0]   w_rd_ext;
  logic [ADDR_WIDTH:0]   w_rd_nxt_ext;
  logic                  w_issue;
  logic                  w_lat_load;
  logic                  w_load;
  logic                  w_fire;
  logic                  w_step;
  logic                  w_rd_clr;
  logic                  w_rd_inc;
  logic                  w_last;

  // Reset is folded in so the combinational BRAM strobe is also quiet during reset.
  assign w_wr_ok      = wr_valid_in && !clear_in && !rst_in && (r_wr_count < C_DEPTH);
  assign w_play_rise  = play_in && !r_play_q;
  assign w_rd_ext     = {1'b0, r_rd_addr};
  assign w_rd_nxt_ext = w_rd_ext + 1'b1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_lat_load = 1'b0;
    w_load     = 1'b0;
    w_fire     = 1'b0;
    w_step     = 1'b0;
    w_rd_clr   = 1'b0;
    w_rd_inc   = 1'b0;
    if (r_state != IDLE && !play_in) begin
      w_next   = IDLE;
      w_rd_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_play_rise) begin
            w_rd_clr = 1'b1;
            w_next   = (r_wr_count == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (w_rd_ext >= r_wr_count) begin
            w_next = DONE;
          end else if (!w_wr_ok) begin
            w_issue    = 1'b1;
            w_lat_load = 1'b1;
            w_next     = WAIT;
          end
        end
        WAIT: begin
          if (r_lat <= LAT_W'(1)) begin
            w_load = 1'b1;
            w_next = SEND;
          end
        end
        SEND: begin
          if (!tx_busy_in) begin
            w_fire = 1'b1;
            w_next = GAP;
          end
        end
        GAP: begin
          if (r_wr_count == '0) begin
            w_next = DONE;
          end else if (!w_last) begin
            w_step = 1'b1;
            w_next = SEND;
          end else begin
`ifdef AUDIO_SCHED_LOOP_EN
            if (w_rd_nxt_ext >= r_wr_count) begin
              w_rd_clr = 1'b1;
            end else begin
              w_rd_inc = 1'b1;
            end
            w_next = ISSUE;
`else
            w_rd_inc = 1'b1;
            w_next   = (w_rd_nxt_ext >= r_wr_count) ? DONE : ISSUE;
`endif
          end
        end
        DONE: begin
          w_next = DONE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_count <= '0;
      r_rd_addr  <= '0;
      r_lat      <= '0;
      r_overflow <= 1'b0;
      r_play_q   <= 1'b0;
    end else begin
      r_play_q <= play_in;

      if (clear_in) begin
        r_wr_count <= '0;
      end else if (w_wr_ok) begin
        r_wr_count <= r_wr_count + 1'b1;
      end

      if (clear_in) begin
        r_overflow <= 1'b0;
      end else if (wr_valid_in && (r_wr_count >= C_DEPTH)) begin
        r_overflow <= 1'b1;
      end

      if (w_rd_clr) begin
        r_rd_addr <= '0;
      end else if (w_rd_inc) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end

      if (w_lat_load) begin
        r_lat <= C_LAT;
      end else if (r_state == WAIT && r_lat != '0) begin
        r_lat <= r_lat - 1'b1;
      end
    end
  end

  word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_in        (w_load),
    .word_in        (bram_dout_in),
    .fire_in        (w_fire),
    .step_in        (w_step),
    .tx_byte_out    (tx_byte_out),
    .tx_trigger_out (tx_trigger_out),
    .last_out       (w_last)
  );

  // Idle port cycles keep the read address parked so a deferred issue needs no extra mux state.
  assign bram_we_out   = w_wr_ok;
  assign bram_addr_out = w_wr_ok ? r_wr_count[ADDR_WIDTH-1:0] : r_rd_addr;
  assign bram_din_out  = w_wr_ok ? wr_data_in : '0;

  assign wr_count_out  = r_wr_count;
  assign rd_addr_out   = r_rd_addr;
  assign overflow_out  = r_overflow;
  assign done_out      = (r_state == DONE);

  logic w_unused;
  assign w_unused = w_issue;

endmodule

`default_nettype wire

// File: tb/tb_audio_bram_scheduler.sv
// ============================================================================
// Module  : tb_audio_bram_scheduler
// Brief   : Directed bench for audio_bram_scheduler with a BRAM and UART model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_bram_scheduler;

  localparam int DEPTH    = 25_250;
  localparam int AW       = 15;
  localparam int WW       = 32;
  localparam int BUSY_CYC = 3;

  logic            clk_100mhz = 1'b0;
  logic            rst_in;
  logic            play_in;
  logic            clear_in;
  logic            wr_valid_in;
  logic [WW-1:0]   wr_data_in;
  logic [AW-1:0]   bram_addr_out;
  logic [WW-1:0]   bram_din_out;
  logic            bram_we_out;
  logic [WW-1:0]   bram_dout_in;
  logic [7:0]      tx_byte_out;
  logic            tx_trigger_out;
  logic            tx_busy_in;
  logic [AW:0]     wr_count_out;
  logic [AW-1:0]   rd_addr_out;
  logic            overflow_out;
  logic            done_out;

  always #5 clk_100mhz = ~clk_100mhz;

  audio_bram_scheduler dut (
    .clk_in         (clk_100mhz),
    .rst_in         (rst_in),
    .play_in        (play_in),
    .clear_in       (clear_in),
    .wr_valid_in    (wr_valid_in),
    .wr_data_in     (wr_data_in),
    .bram_addr_out  (bram_addr_out),
    .bram_din_out   (bram_din_out),
    .bram_we_out    (bram_we_out),
    .bram_dout_in   (bram_dout_in),
    .tx_byte_out    (tx_byte_out),
    .tx_trigger_out (tx_trigger_out),
    .tx_busy_in     (tx_busy_in),
    .wr_count_out   (wr_count_out),
    .rd_addr_out    (rd_addr_out),
    .overflow_out   (overflow_out),
    .done_out       (done_out)
  );

  // Two-stage read pipeline matching a BRAM with output register.
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] q1, q2;
  logic [AW-1:0] last_wr_addr;
  always @(posedge clk_100mhz) begin
    if (bram_we_out) begin
      mem[bram_addr_out] <= bram_din_out;
      last_wr_addr       <= bram_addr_out;
    end
    q1 <= mem[bram_addr_out];
    q2 <= q1;
  end
  assign bram_dout_in = q2;

  int   busy_cnt  = 0;
  int   trig_cnt  = 0;
  int   viol      = 0;
  logic prev_trig = 1'b0;
  logic [7:0] bytes_q [$];
  always @(posedge clk_100mhz) begin
    prev_trig <= tx_trigger_out;
    if (tx_trigger_out) begin
      bytes_q.push_back(tx_byte_out);
      trig_cnt <= trig_cnt + 1;
      if (prev_trig || tx_busy_in) viol <= viol + 1;
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy_in = (busy_cnt != 0);

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic write_word(input logic [WW-1:0] d);
    wr_valid_in = 1'b1;
    wr_data_in  = d;
    tick(1);
    wr_valid_in = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k = 0;
    while (bytes_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(bytes_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done_out && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(done_out), 32'd1);
  endtask

  logic [7:0] exp_bytes [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    int base;
    rst_in      = 1'b1;
    play_in     = 1'b0;
    clear_in    = 1'b0;
    wr_valid_in = 1'b1;
    wr_data_in  = 32'hDEAD_BEEF;
    tick(2);
    check("rst_we", 32'(bram_we_out), 32'd0);
    check("rst_trig", 32'(tx_trigger_out), 32'd0);
    check("rst_count", 32'(wr_count_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_rd", 32'(rd_addr_out), 32'd0);
    wr_valid_in = 1'b0;
    rst_in      = 1'b0;
    tick(1);

    // Record three words and play them back.
    write_word(32'h1122_3344);
    write_word(32'h5566_7788);
    write_word(32'h99AA_BBCC);
    check("t1_count", 32'(wr_count_out), 32'd3);
    base = trig_cnt;
    bytes_q.delete();
    play_in = 1'b1;
    wait_bytes("t1_wait", 12, 500);
    for (int i = 0; i < 12; i++) check($sformatf("t1_byte%0d", i), 32'(bytes_q[i]), 32'(exp_bytes[i]));
`ifdef AUDIO_SCHED_LOOP_EN
    wait_bytes("t6_wait", 16, 300);
    for (int i = 12; i < 16; i++) check($sformatf("t6_byte%0d", i), 32'(bytes_q[i]), 32'(exp_bytes[i-12]));
    check("t6_done", 32'(done_out), 32'd0);
`else
    wait_done("t1_done", 50);
    tick(10);
    check("t1_ntrig", 32'(trig_cnt - base), 32'd12);
`endif
    play_in = 1'b0;
    tick(1);
    check("t1_done_clr", 32'(done_out), 32'd0);
    check("t1_rd_clr", 32'(rd_addr_out), 32'd0);

    // Empty memory: immediate DONE, no triggers.
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    check("t2_count", 32'(wr_count_out), 32'd0);
    base = trig_cnt;
    play_in = 1'b1;
    tick(1);
    check("t2_done", 32'(done_out), 32'd1);
    tick(5);
    check("t2_ntrig", 32'(trig_cnt - base), 32'd0);
    play_in = 1'b0;
    tick(1);

    // Fill past capacity.
    wr_valid_in = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_data_in = 32'(i);
      if (i == DEPTH) begin
        #1;
        check("t3_we_full", 32'(bram_we_out), 32'd0);
      end
      tick(1);
    end
    wr_valid_in = 1'b0;
    check("t3_count", 32'(wr_count_out), 32'(DEPTH));
    check("t3_ovf", 32'(overflow_out), 32'd1);
    check("t3_last_addr", 32'(last_wr_addr), 32'(DEPTH - 1));
    check("t3_last_data", mem[DEPTH-1], 32'(DEPTH - 1));
    wr_valid_in = 1'b1;
    clear_in    = 1'b1;
    #1;
    check("t3_clr_we", 32'(bram_we_out), 32'd0);
    tick(1);
    wr_valid_in = 1'b0;
    clear_in    = 1'b0;
    check("t3_clr_count", 32'(wr_count_out), 32'd0);
    check("t3_clr_ovf", 32'(overflow_out), 32'd0);

    // Write colliding with the read issue cycle.
    write_word(32'h1122_3344);
    write_word(32'h5566_7788);
    bytes_q.delete();
    play_in = 1'b1;
    tick(1);
    wr_valid_in = 1'b1;
    wr_data_in  = 32'h99AA_BBCC;
    #1;
    check("t4_we", 32'(bram_we_out), 32'd1);
    check("t4_waddr", 32'(bram_addr_out), 32'd2);
    tick(1);
    wr_valid_in = 1'b0;
    #1;
    check("t4_rd_we", 32'(bram_we_out), 32'd0);
    check("t4_raddr", 32'(bram_addr_out), 32'd0);
    wait_bytes("t4_wait", 12, 500);
    for (int i = 0; i < 12; i++) check($sformatf("t4_byte%0d", i), 32'(bytes_q[i]), 32'(exp_bytes[i]));
`ifndef AUDIO_SCHED_LOOP_EN
    wait_done("t4_done", 50);
`endif
    play_in = 1'b0;
    tick(2);

    // Abort after the second byte of word 1.
    bytes_q.delete();
    play_in = 1'b1;
    wait_bytes("t5_wait", 6, 300);
    play_in = 1'b0;
    base = trig_cnt;
    tick(30);
    check("t5_ntrig", 32'(trig_cnt - base), 32'd0);
    check("t5_byte5", 32'(bytes_q[5]), 32'h66);
    check("t5_done", 32'(done_out), 32'd0);
    check("t5_rd", 32'(rd_addr_out), 32'd0);
    bytes_q.delete();
    play_in = 1'b1;
    wait_bytes("t5_replay_wait", 1, 100);
    check("t5_replay", 32'(bytes_q[0]), 32'h11);

    // Asynchronous reset in the middle of a word.
    wait_bytes("t7_wait", 2, 100);
    rst_in = 1'b1;
    #1;
    check("t7_trig", 32'(tx_trigger_out), 32'd0);
    check("t7_byte", 32'(tx_byte_out), 32'd0);
    check("t7_count", 32'(wr_count_out), 32'd0);
    check("t7_done", 32'(done_out), 32'd0);
    play_in = 1'b0;
    tick(2);
    rst_in = 1'b0;
    base = trig_cnt;
    tick(20);
    check("t7_ntrig", 32'(trig_cnt - base), 32'd0);
    play_in = 1'b1;
    tick(1);
    check("t7_replay_done", 32'(done_out), 32'd1);
    play_in = 1'b0;
    tick(2);

    check("proto_viol", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
